// File: rtl/alu_cmd_driver_if.sv
// Command/response handshake bundle for alu_cmd_driver.
// master: front end issuing commands; slave: the driver.
//   cmd_*: valid/ready command channel (op, a, b, cin, tag)
//   rsp_*: valid/ready response channel (data, carry, tag, err)
interface alu_cmd_driver_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_cin;
    logic [TAG_W-1:0] cmd_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_carry;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b,
        output cmd_cin, cmd_tag, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data,
        input  rsp_carry, rsp_tag, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b,
        input  cmd_cin, cmd_tag, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data,
        output rsp_carry, rsp_tag, rsp_err
    );
endinterface

// File: rtl/alu_cmd_driver.sv
// Clocked initiator for the one-hot-select asynchronous ALU.
// Ports: clk, rst_n (async low); bus (slave: cmd/rsp handshakes);
//   alu_a/alu_b/alu_cin/alu_s1/alu_s2 drive the ALU;
//   alu_result/alu_carry are captured after SETTLE_CYCLES clocks;
//   err_cnt counts illegal opcodes, saturating at 0xFF.
module alu_cmd_driver #(
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 2,
    parameter int TAG_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_cmd_driver_if.slave  bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    output logic [2:0]       alu_s1,
    output logic [2:0]       alu_s2,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    output logic [7:0]       err_cnt
);
    localparam int CNT_W =
        (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    // Loaded with S-1 so the capture lands on edge N+S.
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [TAG_W-1:0] tag_q;
    logic             is_add;
    logic             accept;
    logic             hs;
    logic             legal;
    logic             op_add;
    logic [2:0]       s1_dec;
    logic [2:0]       s2_dec;

    assign bus.cmd_ready = (state == IDLE);
    assign accept = bus.cmd_valid && bus.cmd_ready;
    assign hs     = bus.rsp_valid && bus.rsp_ready;
    assign op_add = (bus.cmd_op == 3'd1);

    always_comb begin
        s1_dec = 3'b000;
        s2_dec = 3'b000;
        legal  = 1'b1;
        unique case (bus.cmd_op)
            3'd0: s1_dec = 3'b001;
            3'd1: s1_dec = 3'b010;
            3'd2: begin
                s1_dec = 3'b100;
                s2_dec = 3'b001;
            end
            3'd3: begin
                s1_dec = 3'b100;
                s2_dec = 3'b010;
            end
            3'd4: begin
                s1_dec = 3'b100;
                s2_dec = 3'b100;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept)
                    state_nxt = legal ? SETTLE : RESP;
            end
            SETTLE: begin
                if (cnt == '0)
                    state_nxt = RESP;
            end
            RESP: begin
                if (hs)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a         <= '0;
            alu_b         <= '0;
            alu_cin       <= 1'b0;
            alu_s1        <= 3'b000;
            alu_s2        <= 3'b000;
            cnt           <= '0;
            tag_q         <= '0;
            is_add        <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_carry <= 1'b0;
            bus.rsp_tag   <= '0;
            bus.rsp_err   <= 1'b0;
            err_cnt       <= 8'h00;
        end else begin
            if (accept && legal) begin
                alu_a   <= bus.cmd_a;
                alu_b   <= bus.cmd_b;
                alu_cin <= op_add & bus.cmd_cin;
                alu_s1  <= s1_dec;
                alu_s2  <= s2_dec;
                is_add  <= op_add;
                tag_q   <= bus.cmd_tag;
                cnt     <= CNT_LOAD;
            end
            // Illegal ops answer at once and leave the ALU alone.
            if (accept && !legal) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_err   <= 1'b1;
                bus.rsp_data  <= '0;
                bus.rsp_carry <= 1'b0;
                bus.rsp_tag   <= bus.cmd_tag;
                if (err_cnt != 8'hFF)
                    err_cnt <= err_cnt + 8'd1;
            end
            if (state == SETTLE) begin
                if (cnt == '0) begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_data  <= alu_result;
                    bus.rsp_carry <= is_add & alu_carry;
                    bus.rsp_tag   <= tag_q;
                    alu_s1        <= 3'b000;
                    alu_s2        <= 3'b000;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
            if (hs) begin
                bus.rsp_valid <= 1'b0;
                bus.rsp_err   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_cmd_driver.sv
// Scoreboard bench for alu_cmd_driver with a behavioural ALU.
// Random and directed commands; monitor checks every response.
module tb_alu_cmd_driver;
    localparam int S = 2;

    typedef struct {
        logic [15:0] data;
        logic        carry;
        logic [3:0]  tag;
        logic        err;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] alu_a, alu_b, alu_result;
    logic        alu_cin, alu_carry;
    logic [2:0]  alu_s1, alu_s2;
    logic [7:0]  err_cnt;

    alu_cmd_driver_if #(.WIDTH(16), .TAG_W(4)) bus ();

    alu_cmd_driver #(
        .WIDTH(16), .SETTLE_CYCLES(S), .TAG_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_s1(alu_s1), .alu_s2(alu_s2),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; junk carry on non-ADD ops and junk
    // result when idle, so the driver must mask/capture properly.
    logic [31:0] prod;
    logic [16:0] sum;
    always_comb begin
        prod = 32'(alu_a) * 32'(alu_b);
        sum  = 17'(alu_a) + 17'(alu_b) + 17'(alu_cin);
        alu_result = 16'hDEAD;
        alu_carry  = 1'b1;
        case (alu_s1)
            3'b001: begin
                alu_result = prod[15:0];
                alu_carry  = |prod[31:16];
            end
            3'b010: {alu_carry, alu_result} = sum;
            3'b100: begin
                case (alu_s2)
                    3'b001: alu_result = alu_a & alu_b;
                    3'b010: alu_result = alu_a | alu_b;
                    3'b100: alu_result = alu_a ^ alu_b;
                    default: alu_result = 16'hBEEF;
                endcase
            end
            default: ;
        endcase
    end

    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   err_model = 0;
    int   hs_cyc = -100;
    int   acc2 = -1;
    bit   b2_done = 0;
    bit   hold_rsp = 0;
    bit   held = 0;
    exp_t q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [127:0] act,
                       logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(int op, int a, int b,
                                   int cin, int tag);
        exp_t e;
        int   r;
        e.data  = 16'h0;
        e.carry = 1'b0;
        e.tag   = 4'(tag);
        e.err   = 1'b0;
        e.acc   = 0;
        case (op)
            0: r = (a * b) % 65536;
            1: begin
                r = a + b + cin;
                e.carry = (r >= 65536);
                r = r % 65536;
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            default: begin
                r = 0;
                e.err = 1'b1;
            end
        endcase
        e.data = 16'(r);
        return e;
    endfunction

    function automatic logic [2:0] exp_s1(int op);
        if (op == 0) return 3'b001;
        if (op == 1) return 3'b010;
        if (op <= 4) return 3'b100;
        return 3'b000;
    endfunction

    function automatic logic [2:0] exp_s2(int op);
        if (op == 2) return 3'b001;
        if (op == 3) return 3'b010;
        if (op == 4) return 3'b100;
        return 3'b000;
    endfunction

    task automatic issue(int op, int a, int b, int cin,
                         int tag, output int acc);
        bit   r;
        exp_t e;
        @(negedge clk);
        bus.cmd_op    = 3'(op);
        bus.cmd_a     = 16'(a);
        bus.cmd_b     = 16'(b);
        bus.cmd_cin   = 1'(cin);
        bus.cmd_tag   = 4'(tag);
        bus.cmd_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            r = bus.cmd_ready;
            @(posedge clk);
            if (r) begin
                #1;
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            chk("accept_timeout", 1, 0);
        end else begin
            e = model(op, a, b, cin, tag);
            e.acc = acc;
            q.push_back(e);
            if (e.err && err_model < 255) err_model++;
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'($urandom);
        bus.cmd_a     = 16'($urandom);
        if (acc >= 0) begin
            if (op <= 4) begin
                chk("alu_s1", alu_s1, exp_s1(op));
                chk("alu_s2", alu_s2, exp_s2(op));
                chk("alu_ab", {alu_a, alu_b},
                    {16'(a), 16'(b)});
                chk("alu_cin", alu_cin,
                    (op == 1) ? 1'(cin) : 1'b0);
            end else begin
                chk("alu_s1_illegal", alu_s1, 3'b000);
            end
        end
    endtask

    // Monitor: pops the scoreboard on each new response and
    // checks stability while the response is back-pressured.
    logic [15:0] sd;
    logic [3:0]  st;
    logic        sc, se;
    always @(negedge clk) begin
        exp_t e;
        bit   rdy;
        if (!rst_n) begin
            held = 0;
            bus.rsp_ready = 1'b0;
        end else begin
            rdy = hold_rsp ? 1'b0 : ($urandom_range(0, 2) != 0);
            if (bus.rsp_valid) begin
                chk("cmd_ready_in_resp", bus.cmd_ready, 1'b0);
                if (!held) begin
                    if (q.size() == 0) begin
                        chk("unexpected_rsp", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("rsp_data", bus.rsp_data, e.data);
                        chk("rsp_carry", bus.rsp_carry, e.carry);
                        chk("rsp_tag", bus.rsp_tag, e.tag);
                        chk("rsp_err", bus.rsp_err, e.err);
                        chk("latency", cyc - e.acc,
                            e.err ? 0 : S);
                    end
                    sd = bus.rsp_data;
                    st = bus.rsp_tag;
                    sc = bus.rsp_carry;
                    se = bus.rsp_err;
                end else begin
                    chk("rsp_stable",
                        {bus.rsp_data, bus.rsp_tag,
                         bus.rsp_carry, bus.rsp_err},
                        {sd, st, sc, se});
                end
                if (rdy) hs_cyc = cyc + 1;
                held = !rdy;
            end else begin
                held = 0;
            end
            bus.rsp_ready = rdy;
        end
    end

    function automatic logic [127:0] outs();
        return {bus.rsp_valid, bus.rsp_err, bus.rsp_data,
                bus.rsp_carry, bus.rsp_tag, alu_a, alu_b,
                alu_cin, alu_s1, alu_s2, err_cnt};
    endfunction

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !bus.rsp_valid) begin
                ok = 1;
                break;
            end
        end
        chk("drain", ok, 1);
    endtask

    initial begin
        int acc;
        int op;
        bit seen;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_a     = 16'h0;
        bus.cmd_b     = 16'h0;
        bus.cmd_cin   = 1'b0;
        bus.cmd_tag   = 4'h0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", bus.cmd_ready, 1'b1);

        issue(1, 16'hFFFF, 16'h0001, 0, 1, acc);
        issue(0, 16'h00FF, 16'h0003, 1, 2, acc);
        issue(0, 16'h0100, 16'h0100, 0, 3, acc);
        issue(4, 16'hA5A5, 16'h5A5A, 1, 4, acc);
        issue(2, 16'hF0F0, 16'h0FF0, 0, 5, acc);
        issue(3, 16'hF000, 16'h000F, 1, 6, acc);
        issue(1, 16'h1234, 16'h4321, 1, 7, acc);
        drain();

        chk("err_cnt_zero", err_cnt, 8'h00);
        issue(6, 16'h1111, 16'h2222, 1, 9, acc);
        drain();
        chk("err_cnt_one", err_cnt, 8'h01);

        hold_rsp = 1;
        issue(1, 16'h8000, 16'h8000, 1, 10, acc);
        fork
            begin
                issue(4, 16'h00FF, 16'h0F0F, 0, 11, acc2);
                b2_done = 1;
            end
        join_none
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                seen = 1;
                break;
            end
        end
        chk("bp_rsp_seen", seen, 1);
        repeat (5) @(negedge clk);
        hold_rsp = 0;
        for (int i = 0; i < 100; i++) begin
            if (b2_done) break;
            @(negedge clk);
        end
        chk("bp_second_accept", b2_done, 1);
        chk("bp_accept_cycle", acc2, hs_cyc + 1);
        drain();

        for (int i = 0; i < 40; i++) begin
            op = (i % 5 == 4) ? $urandom_range(5, 7)
                              : $urandom_range(0, 4);
            issue(op, $urandom_range(0, 65535),
                  $urandom_range(0, 65535),
                  $urandom_range(0, 1),
                  $urandom_range(0, 15), acc);
        end
        drain();
        chk("err_cnt_random", err_cnt, 8'(err_model));

        for (int i = 0; i < 300; i++)
            issue($urandom_range(5, 7), i, i, 0, i % 16, acc);
        drain();
        chk("err_cnt_sat", err_cnt, 8'hFF);
        chk("err_model_sat", err_model, 255);

        issue(1, 16'h0F0F, 16'h0101, 1, 12, acc);
        #3;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_settle", outs(), 128'h0);
        q.delete();
        err_model = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst2", bus.cmd_ready, 1'b1);
        issue(1, 16'h7FFF, 16'h0001, 1, 13, acc);
        drain();
        chk("err_cnt_after_rst", err_cnt, 8'(err_model));

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule
